// File: rtl/lane_pkg.sv
// Shared lane constants and symbol-kind encoding used by striping, serializer and deserializer.
package lane_pkg;

    localparam int          LANE_WIDTH = 8;
    localparam logic [7:0]  LANE_COMMA = 8'hBC;  // K28.5

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_DATA = 2'b01,
        KIND_K    = 2'b10
    } kind_e;

endpackage

// File: rtl/lane_serializer_bit_counter.sv
// 3-bit wrapping bit index; reset parks it on 7 so the first cycle after reset is a load slot.
module bit_counter (
    input  logic clk,
    input  logic reset,
    output logic last
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 3'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 3'd7;
        else       cnt_q <= cnt_d;
    end

    assign last = (cnt_q == 3'd7);

endmodule

// File: rtl/lane_serializer.sv
// Per-lane MSB-first parallel-to-serial stage with valid/ready intake.
// Optional feature: define LANE_SERIALIZER_IDLE_EN to fill idle slots with COMMA symbols.
module lane_serializer
    import lane_pkg::*;
#(
    parameter int               WIDTH = LANE_WIDTH,
    parameter logic [WIDTH-1:0] COMMA = LANE_COMMA
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             valid_out,
    output logic             k_out
);

`ifdef LANE_SERIALIZER_IDLE_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif

    logic             last;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    kind_e            kind_q;
    kind_e            kind_d;

    bit_counter u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .last  (last)
    );

    // NOTE: defaults first so every path assigns sr_d/kind_d and no latch is inferred.
    always_comb begin
        sr_d   = {sr_q[WIDTH-2:0], 1'b0};
        kind_d = kind_q;
        if (last) begin
            if (valid_in) begin
                sr_d   = data_in;
                kind_d = KIND_DATA;
            end else begin
                sr_d   = IDLE_EN ? COMMA : '0;
                kind_d = IDLE_EN ? KIND_K : KIND_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= '0;
            kind_q <= KIND_NONE;
        end else begin
            sr_q   <= sr_d;
            kind_q <= kind_d;
        end
    end

    // Gated by reset so the line is quiet from the very first reset cycle, not one edge later.
    assign ready_out = last && !reset;
    assign data_out  = sr_q[WIDTH-1] && !reset;
    assign valid_out = (kind_q == KIND_DATA) && !reset;

`ifdef LANE_SERIALIZER_IDLE_EN
    assign k_out = (kind_q == KIND_K) && !reset;
`else
    assign k_out = 1'b0;
`endif

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer: reset, single byte, back-to-back, idle fill, backpressure, mid-byte reset.
module tb_lane_serializer;

`ifdef LANE_SERIALIZER_IDLE_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif
    localparam logic [7:0] IDLE_BYTE = IDLE_EN ? 8'hBC : 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       valid_out;
    logic       k_out;

    int checks = 0;
    int errors = 0;

    lane_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .k_out     (k_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_data"},  data_out,  1'b0);
        check({tag, "_valid"}, valid_out, 1'b0);
        check({tag, "_k"},     k_out,     1'b0);
        check({tag, "_ready"}, ready_out, 1'b0);
    endtask

    // Checks eight consecutive bit cycles and stops in the last one (the load slot).
    task automatic check_byte(input string tag, input logic [7:0] b, input logic v, input logic k);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_bit%0d", tag, 7 - i), data_out, b[7-i]);
            check($sformatf("%s_valid%0d", tag, i), valid_out, v);
            check($sformatf("%s_k%0d", tag, i), k_out, k);
            check($sformatf("%s_ready%0d", tag, i), ready_out, (i == 7));
            if (i < 7) tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        tick();
        tick();
        check_quiet("in_reset");

        reset = 1'b0;
        #1;
        check("ready_after_reset", ready_out, 1'b1);
        check("valid_after_reset", valid_out, 1'b0);

        // Single byte in the first ready cycle.
        data_in  = 8'hA5;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check_byte("a5", 8'hA5, 1'b1, 1'b0);

        // Back-to-back bytes held valid continuously.
        valid_in = 1'b1;
        data_in  = 8'h0F;
        tick();
        data_in = 8'hF0;
        check_byte("b2b_0f", 8'h0F, 1'b1, 1'b0);
        tick();
        valid_in = 1'b0;
        check_byte("b2b_f0", 8'hF0, 1'b1, 1'b0);

        // Three idle slots, then a byte right on the slot boundary.
        tick();
        for (int s = 0; s < 3; s++) begin
            check_byte($sformatf("idle%0d", s), IDLE_BYTE, 1'b0, IDLE_EN);
            if (s < 2) tick();
        end
        data_in  = 8'h3C;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check_byte("3c", 8'h3C, 1'b1, 1'b0);

        // Backpressure: byte offered at cnt=3 waits for the load slot.
        tick();
        tick();
        tick();
        tick();
        data_in  = 8'h81;
        valid_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("bp_ready_cnt%0d", 3 + j), ready_out, 1'b0);
            check($sformatf("bp_valid_cnt%0d", 3 + j), valid_out, 1'b0);
            tick();
        end
        check("bp_ready_cnt7", ready_out, 1'b1);
        tick();
        valid_in = 1'b0;
        check("bp_81_bit7", data_out, 1'b1);
        check("bp_81_valid", valid_out, 1'b1);
        tick();
        tick();
        tick();
        tick();
        check("bp_81_bit3", data_out, 1'b0);
        check("bp_81_valid_cnt4", valid_out, 1'b1);

        // Mid-byte reset at cnt=4 with a competing valid_in: reset wins.
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'hFF;
        #1;
        check_quiet("mid_reset_c0");
        for (int r = 1; r <= 3; r++) begin
            tick();
            check_quiet($sformatf("mid_reset_c%0d", r));
        end

        reset   = 1'b0;
        data_in = 8'hC3;
        #1;
        check("ready_after_mid_reset", ready_out, 1'b1);
        check("dropped_valid", valid_out, 1'b0);
        check("dropped_data", data_out, 1'b0);
        tick();
        valid_in = 1'b0;
        check_byte("c3", 8'hC3, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
